// File: rtl/stencil_window_ub.sv
// stencil_window_ub: streaming K x K stencil-window generator.
// Takes one pixel per accepted cycle in raster order. The window of the most
// recent K rows and K columns is presented one cycle after the pixel that
// completes it.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clr          synchronous frame restart; a pixel accepted in the same
//                cycle becomes (0,0) of the new frame
//   in_valid     in_data carries a pixel; when low, the cycle is a stall
//   in_data      pixel value, WIDTH bits
//   out_valid    out_window holds a complete in-frame window (one-cycle pulse)
//   out_window   element i = ky*K+kx sits at [i*WIDTH +: WIDTH];
//                it holds pixel (row-(K-1)+ky, col-(K-1)+kx)
//   frame_done   pulses together with the window of the frame's last pixel

// One window row: a K-deep shift register fed by a row tap.
// sr[K-1] holds the newest pixel and sr[0] the oldest.
module stencil_window_ub_row #(
  parameter int WIDTH = 16,
  parameter int K     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      adv,
  input  logic [WIDTH-1:0]          tap,
  output logic [K-1:0][WIDTH-1:0]   sr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sr <= '0;
    else if (adv) sr <= {tap, sr[K-1:1]};
  end
endmodule

module stencil_window_ub #(
  parameter int WIDTH = 16,
  parameter int K     = 3,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  output logic [K*K*WIDTH-1:0]   out_window,
  output logic                   frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col, pcol;
  logic [RW-1:0] row, prow;
  logic          col_last, row_last, in_frame;

  // Position of the pixel offered this cycle; clr makes it (0,0).
  assign pcol     = clr ? '0 : col;
  assign prow     = clr ? '0 : row;
  assign col_last = (pcol == CW'(IMG_W-1));
  assign row_last = (prow == RW'(IMG_H-1));
  // Counters restart with every frame, so this mask also hides line data
  // left over from an earlier frame or from before a reset.
  assign in_frame = (prow >= RW'(K-1)) && (pcol >= CW'(K-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (clr) begin
        row <= '0;
        col <= '0;
      end
      if (in_valid) begin
        out_valid  <= in_frame;
        frame_done <= row_last && col_last;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : prow + 1'b1;
        end else begin
          col <= pcol + 1'b1;
          row <= prow;
        end
      end
    end
  end

  // Row taps: taps[K-1] is the live pixel, taps[j] the pixel one row above
  // taps[j+1] at the same column.
  logic [K-2:0][WIDTH-1:0]        rd;
  logic [K-1:0][WIDTH-1:0]        taps;
  logic [K-1:0][K-1:0][WIDTH-1:0] win;

  assign taps = {in_data, rd};

  // Row delays share the column address. The read returns the old word
  // while the same address is written, which is what moves data up one row.
  for (genvar j = 0; j < K-1; j++) begin : g_dly
    logic [WIDTH-1:0] mem [IMG_W];
    logic [WIDTH-1:0] wr;
    if (j == K-2) begin : g_top
      assign wr = in_data;
    end else begin : g_mid
      assign wr = rd[j+1];
    end
    always_ff @(posedge clk) begin
      if (in_valid) mem[pcol] <= wr;
    end
    assign rd[j] = mem[pcol];
  end

  stencil_window_ub_row #(.WIDTH(WIDTH), .K(K)) u_row [K-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (in_valid),
    .tap   (taps),
    .sr    (win)
  );

  // win[ky][kx] flattens to element ky*K+kx.
  assign out_window = win;
endmodule

// File: tb/tb_stencil_window_ub.sv
// Scoreboard bench for stencil_window_ub (K=3, 8x6 image, 16-bit pixels).
// Stimulus keeps a picture of the current frame and queues the expected
// window for each qualifying pixel; a monitor compares on every out_valid.
module tb_stencil_window_ub;
  localparam int W = 16, K = 3, IW = 8, IH = 6;
  localparam int WB = K*K*W;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid, frame_done;
  logic [WB-1:0] out_window;

  stencil_window_ub #(.WIDTH(W), .K(K), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_window (out_window),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WB-1:0] w;
    bit            done;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   img [IH][IW];
  int   mr = 0, mc = 0;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: a pixel lands at (mr,mc); if a full KxK neighbourhood exists
  // above-left of it inside this frame, that neighbourhood is the expected window.
  task automatic model(input logic [W-1:0] d, input logic c);
    exp_t e;
    if (c) begin mr = 0; mc = 0; end
    img[mr][mc] = int'(d);
    if (mr >= K-1 && mc >= K-1) begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          e.w[(ky*K+kx)*W +: W] = W'(img[mr-(K-1)+ky][mc-(K-1)+kx]);
      e.done = (mr == IH-1) && (mc == IW-1);
      q.push_back(e);
    end
    mc++;
    if (mc == IW) begin
      mc = 0;
      mr = (mr == IH-1) ? 0 : mr + 1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic c);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; clr = c;
    model(d, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; clr = 1'b0; in_data = W'($urandom);
    end
  endtask

  task automatic at_edge();
    @(posedge clk); #1;
  endtask

  // Window for pixel (r,c) when each pixel value is row*IW+col+off.
  function automatic logic [WB-1:0] exp_rc(input int r, input int c, input int off);
    logic [WB-1:0] w;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        w[(ky*K+kx)*W +: W] = W'((r-(K-1)+ky)*IW + (c-(K-1)+kx) + off);
    return w;
  endfunction

  // Monitor
  initial begin
    logic [WB-1:0] prev;
    logic          s_iv, s_clr, s_rst;
    int            vcount;
    exp_t          e;
    prev = '0; vcount = 0;
    forever begin
      @(posedge clk);
      s_iv = in_valid; s_clr = clr; s_rst = rst_n;
      #1;
      if (!s_rst || !rst_n) begin
        vcount = 0;
      end else begin
        if (!s_iv) begin
          chk("stall_valid", WB'(out_valid), '0);
          chk("stall_hold", out_window, prev);
        end else if (out_valid) begin
          vcount++;
          if (q.size() == 0) begin
            chk("unexpected_valid", WB'(out_valid), '0);
          end else begin
            e = q.pop_front();
            chk("window", out_window, e.w);
            chk("frame_done", WB'(frame_done), WB'(e.done));
          end
          if (frame_done) begin
            chk("frame_count", WB'(vcount), WB'((IW-K+1)*(IH-K+1)));
            vcount = 0;
          end
        end else begin
          chk("done_without_valid", WB'(frame_done), '0);
        end
        if (s_clr) begin
          chk("clr_valid", WB'(out_valid), '0);
          vcount = 0;
        end
      end
      prev = out_window;
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_valid", WB'(out_valid), '0);
    chk("rst_window", out_window, '0);
    chk("rst_done", WB'(frame_done), '0);
    @(negedge clk); rst_n = 1'b1;

    // Frame 1: continuous, pixel = row*8+col
    for (int p = 0; p < IW*IH; p++) begin
      send(W'(p), 1'b0);
      if (p == 17 || p == 24 || p == 25) begin
        at_edge(); chk($sformatf("mask_p%0d", p), WB'(out_valid), '0);
      end
      if (p == 18) begin
        at_edge();
        chk("fill_valid", WB'(out_valid), WB'(1));
        chk("fill_window", out_window, exp_rc(2, 2, 0));
      end
      if (p == 26) begin
        at_edge();
        chk("col2_valid", WB'(out_valid), WB'(1));
        chk("col2_window", out_window, exp_rc(3, 2, 0));
      end
      if (p == IW*IH-1) begin
        at_edge();
        chk("last_done", WB'(frame_done), WB'(1));
        chk("last_elem8", WB'(out_window[WB-1 -: W]), WB'(47));
      end
    end

    // Frame 2: distinct data so stale frame-1 lines would be visible
    for (int p = 0; p < IW*IH; p++) begin
      send(W'(p + 1000), 1'b0);
      if (p == 17) begin at_edge(); chk("f2_p17_valid", WB'(out_valid), '0); end
      if (p == 18) begin at_edge(); chk("f2_p18_window", out_window, exp_rc(2, 2, 1000)); end
    end

    // Frame 3: random data with random stall gaps
    for (int p = 0; p < IW*IH; p++) begin
      send(W'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
    end

    // Frame 4: asynchronous reset in row 3, right after a valid window
    for (int p = 0; p <= 26; p++) send(W'(p), 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_valid", WB'(out_valid), '0);
    chk("arst_window", out_window, '0);
    chk("arst_done", WB'(frame_done), '0);
    mr = 0; mc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < IW*IH; p++) begin
      send(W'($urandom), 1'b0);
      if (p == 17) begin at_edge(); chk("arst_p18_valid", WB'(out_valid), '0); end
      if (p == 18) begin at_edge(); chk("arst_p19_valid", WB'(out_valid), WB'(1)); end
    end

    // Frame 5: clr with in_valid at (4,5), data 100
    for (int p = 0; p < 4*IW+5; p++) send(W'(p), 1'b0);
    send(W'(100), 1'b1);
    for (int p = 1; p < IW*IH; p++) begin
      send(W'(100 + p), 1'b0);
      if (p == 17) begin at_edge(); chk("clr_17_valid", WB'(out_valid), '0); end
      if (p == 18) begin
        at_edge();
        chk("clr_18_valid", WB'(out_valid), WB'(1));
        chk("clr_18_window", out_window, exp_rc(2, 2, 100));
      end
    end

    idle(4);
    chk("queue_empty", WB'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
